// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions.
// Fetch FSM encoding, PC increment and the default reset vector.
package mips_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DROP = 3'd3,
        S_HOLD = 3'd4
    } fetch_state_e;

    localparam int unsigned PC_INC       = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch stage.
// A load always wins over an increment; loaded targets are word-aligned.
module fetch_pc_reg
    import mips_pkg::*;
#(
    parameter int unsigned         ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_i,
    input  logic [ADDR_W-1:0] ld_pc_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (ld_i) begin
            pc_d = {ld_pc_i[ADDR_W-1:2], 2'b00};
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(PC_INC);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: one outstanding imem request,
// {pc, instr} delivered to IF/ID over valid/ready.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] out_pc_q;
    logic [DATA_W-1:0] out_instr_q;
    logic [ADDR_W-1:0] pc;
    logic              pc_inc;

    // Advance only on a response that is actually captured.
    assign pc_inc = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst     (rst),
        .ld_i    (redirect_valid),
        .ld_pc_i (redirect_pc),
        .inc_i   (pc_inc),
        .pc_o    (pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_pc_q    <= '0;
            out_instr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_REQ;
                S_REQ: begin
                    if (imem_req_ready) begin
                        state_q <= redirect_valid ? S_DROP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        state_q <= imem_rsp_valid ? S_REQ : S_DROP;
                    end else if (imem_rsp_valid) begin
                        out_pc_q    <= pc;
                        out_instr_q <= imem_rsp_data;
                        state_q     <= S_HOLD;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid) begin
                        state_q <= S_REQ;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid || out_ready) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc;
    assign out_valid      = (state_q == S_HOLD);
    assign out_pc         = out_pc_q;
    assign out_instr      = out_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed cycle table, reset
// sequence, then random traffic against a transaction-level model.
module tb_fetch_unit;

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        rr;
        logic        sv;
        logic [31:0] sd;
        logic        ordy;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_ov;
        logic [31:0] e_opc;
        logic [31:0] e_oi;
    } vec_t;

    localparam logic [31:0] I0  = 32'h2002_0005;
    localparam logic [31:0] I1  = 32'h8C01_0004;
    localparam logic [31:0] I2  = 32'h1111_2222;
    localparam logic [31:0] I3  = 32'h3333_4444;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;
    localparam logic [31:0] TOP = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic vec_t mk(
        input logic rd, input logic [31:0] rpc, input logic rr,
        input logic sv, input logic [31:0] sd, input logic ordy,
        input logic e_rv, input logic [31:0] e_ra, input logic e_ov,
        input logic [31:0] e_opc, input logic [31:0] e_oi);
        vec_t v;
        v.rd = rd; v.rpc = rpc; v.rr = rr; v.sv = sv; v.sd = sd;
        v.ordy = ordy; v.e_rv = e_rv; v.e_ra = e_ra; v.e_ov = e_ov;
        v.e_opc = e_opc; v.e_oi = e_oi;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic [31:0] rpc,
                         input logic rr, input logic sv,
                         input logic [31:0] sd, input logic ordy);
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_req_ready = rr;
        imem_rsp_valid = sv;
        imem_rsp_data  = sd;
        out_ready      = ordy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, '0, 0, 0, '0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl[29];

    initial begin
        // Row i: outputs expected at negedge i, inputs applied for the next edge.
        tbl[0]  = mk(0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1, I0, 0,  0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0,   0, 4, 1, 0, I0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0,   0, 4, 1, 0, I0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0,   0, 4, 1, 0, I0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0,   0, 4, 1, 0, I0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0,   0, 4, 1, 0, I0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 1,   0, 4, 1, 0, I0);
        tbl[9]  = mk(0, 0, 0, 1, BAD, 0, 1, 4, 0, 0, I0);
        tbl[10] = mk(0, 0, 1, 0, 0, 0,   1, 4, 0, 0, I0);
        tbl[11] = mk(0, 0, 0, 1, I1, 1,  0, 4, 0, 0, I0);
        tbl[12] = mk(0, 0, 0, 0, 0, 1,   0, 8, 1, 4, I1);
        tbl[13] = mk(1, 32'h40, 1, 0, 0, 0,    1, 8, 0, 4, I1);
        tbl[14] = mk(0, 0, 0, 1, BAD, 0,       0, 32'h40, 0, 4, I1);
        tbl[15] = mk(0, 0, 1, 0, 0, 0,         1, 32'h40, 0, 4, I1);
        tbl[16] = mk(1, 32'h103, 0, 1, BAD, 0, 0, 32'h40, 0, 4, I1);
        tbl[17] = mk(0, 0, 1, 0, 0, 0,         1, 32'h100, 0, 4, I1);
        tbl[18] = mk(1, 32'h40, 0, 0, 0, 0,    0, 32'h100, 0, 4, I1);
        tbl[19] = mk(0, 0, 0, 0, 0, 0,         0, 32'h40, 0, 4, I1);
        tbl[20] = mk(0, 0, 0, 1, BAD, 0,       0, 32'h40, 0, 4, I1);
        tbl[21] = mk(0, 0, 1, 0, 0, 0,         1, 32'h40, 0, 4, I1);
        tbl[22] = mk(0, 0, 0, 1, I2, 0,        0, 32'h40, 0, 4, I1);
        tbl[23] = mk(1, TOP, 0, 0, 0, 0,       0, 32'h44, 1, 32'h40, I2);
        tbl[24] = mk(0, 0, 1, 0, 0, 0,         1, TOP, 0, 32'h40, I2);
        tbl[25] = mk(0, 0, 0, 1, I3, 1,        0, TOP, 0, 32'h40, I2);
        tbl[26] = mk(0, 0, 0, 0, 0, 1,         0, 0, 1, TOP, I3);
        tbl[27] = mk(0, 0, 1, 0, 0, 0,         1, 0, 0, TOP, I3);
        tbl[28] = mk(0, 0, 0, 0, 0, 0,         0, 0, 0, TOP, I3);

        do_reset();
        for (int i = 0; i < 29; i++) begin
            chk($sformatf("row%0d req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_rv));
            chk($sformatf("row%0d req_addr", i), imem_req_addr, tbl[i].e_ra);
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("row%0d out_pc", i), out_pc, tbl[i].e_opc);
            chk($sformatf("row%0d out_instr", i), out_instr, tbl[i].e_oi);
            drive(tbl[i].rd, tbl[i].rpc, tbl[i].rr, tbl[i].sv, tbl[i].sd, tbl[i].ordy);
            @(negedge clk);
        end

        // Asynchronous reset while waiting on a response.
        #2 rst = 1'b1;
        #1;
        chk("async_rst out_pc", out_pc, 32'h0);
        chk("async_rst out_instr", out_instr, 32'h0);
        chk("async_rst out_valid", 32'(out_valid), 32'h0);
        chk("async_rst req_valid", 32'(imem_req_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, '0, 0, 1, BAD, 1);
        @(negedge clk);
        chk("late_rsp req_valid", 32'(imem_req_valid), 32'h1);
        chk("late_rsp req_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        chk("late_rsp out_valid", 32'(out_valid), 32'h0);
        chk("late_rsp still_req", 32'(imem_req_valid), 32'h1);
        drive(0, '0, 1, 0, '0, 1);
        @(negedge clk);
        drive(0, '0, 0, 1, I0, 1);
        @(negedge clk);
        chk("post_rst out_valid", 32'(out_valid), 32'h1);
        chk("post_rst out_pc", out_pc, 32'h0);
        chk("post_rst out_instr", out_instr, I0);

        run_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Model: the next delivered instruction is the word after the last one
    // delivered, or the aligned redirect target if a redirect came since.
    task automatic run_random();
        logic [31:0] exp_pc;
        logic        pending;
        logic        pend_start;
        logic [31:0] pend_addr;
        int          cnt;
        int          n_del;
        logic        rd, rr, sv, ordy;
        logic [31:0] rpc, sd;
        logic        rv, ov;
        logic [31:0] ra, opc, oi;
        logic        p_hold;
        logic [31:0] p_opc, p_oi;

        do_reset();
        exp_pc  = 32'h0;
        pending = 1'b0;
        pend_addr = '0;
        cnt     = 0;
        n_del   = 0;
        p_hold  = 1'b0;
        p_opc   = '0;
        p_oi    = '0;

        for (int c = 0; c < 4000; c++) begin
            rv = imem_req_valid; ra = imem_req_addr;
            ov = out_valid; opc = out_pc; oi = out_instr;

            if (p_hold) begin
                chk("stall out_valid", 32'(ov), 32'h1);
                chk("stall out_pc", opc, p_opc);
                chk("stall out_instr", oi, p_oi);
            end

            pend_start = pending;
            sv = 1'b0;
            sd = $urandom;
            if (pending) begin
                if (cnt == 0) begin
                    sv = 1'b1;
                    sd = memf(pend_addr);
                    pending = 1'b0;
                end else begin
                    cnt--;
                end
            end else begin
                sv = ($urandom_range(0, 9) == 0);
            end
            rr   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            rd   = ($urandom_range(0, 11) == 0);
            rpc  = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));

            if (rv) begin
                chk("one_outstanding", 32'(pend_start), 32'h0);
                chk("req_addr", ra, exp_pc);
            end
            if (ov && ordy) begin
                chk("deliver pc", opc, exp_pc);
                chk("deliver instr", oi, memf(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_del++;
            end
            if (rd) exp_pc = rpc & 32'hFFFF_FFFC;
            if (rv && rr) begin
                pending   = 1'b1;
                pend_addr = ra;
                cnt       = $urandom_range(0, 3);
            end

            p_hold = ov && !ordy && !rd;
            p_opc  = opc;
            p_oi   = oi;
            drive(rd, rpc, rr, sv, sd, ordy);
            @(negedge clk);
        end
        n_cmp++;
        if (n_del < 100) begin
            n_bad++;
            $display("FAIL progress: delivered %0d expected at least 100", n_del);
        end
    endtask

endmodule
